// File: rtl/muldiv_engine_if.sv
// muldiv_engine_if -- request/response bundle for muldiv_engine.
//   start, op[1:0], srca[31:0], srcb[31:0], flush : requester -> engine
//   busy, done, hi[31:0], lo[31:0]                : engine -> requester
// master modport is the requester side, slave modport is the engine side.
interface muldiv_engine_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, srca, srcb, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_engine.sv
// muldiv_engine -- multi-cycle 32-bit multiply / divide unit.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : muldiv_engine_if.slave
//           start/op/srca/srcb/flush in, busy/done/hi/lo out
//   op    : 0=MULT 1=MULTU 2=DIV 3=DIVU
//   MUL_LAT (1..4) : cycles from accept to done for MULT/MULTU.
// Build option MULDIV_DIV_EN: when defined, DIV/DIVU use a 32-iteration
// restoring divider (done 33 cycles after accept). When undefined, no divider
// is built and DIV/DIVU complete the cycle after accept with hi=lo=0.
module muldiv_engine #(
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   muldiv_engine_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

   state_t      state;
   logic        busy_r;
   logic        done_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [63:0] prod_r;
   logic [2:0]  mul_cnt;

   logic        signed_op;
   logic        is_div;
   logic        accept;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] product;

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // busy_r stays high through the done cycle, so this also blocks
   // a start that arrives while the result is being presented.
   always_comb begin
      signed_op = ~bus.op[0];
      is_div    = bus.op[1];
      accept    = bus.start & ~busy_r & ~bus.flush & (state == IDLE);
      // low 64 bits of the 64x64 product give the correct signed or
      // unsigned 32x32 result depending on the extension
      ext_a     = {{32{signed_op & bus.srca[31]}}, bus.srca};
      ext_b     = {{32{signed_op & bus.srcb[31]}}, bus.srcb};
      product   = ext_a * ext_b;
   end

`ifdef MULDIV_DIV_EN
   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] dvs_r;
   logic [4:0]  div_cnt;
   logic        neg_q;
   logic        neg_r;
   logic        div0;

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] rem_nx;
   logic [31:0] quo_nx;
   logic [31:0] rem_fix;
   logic [31:0] quo_fix;

   always_comb begin
      abs_a   = (signed_op & bus.srca[31]) ? (32'd0 - bus.srca) : bus.srca;
      abs_b   = (signed_op & bus.srcb[31]) ? (32'd0 - bus.srcb) : bus.srcb;
      // one restoring step: shift next dividend bit in, subtract if it fits
      shifted = {rem_r, quo_r[31]};
      trial   = shifted - {1'b0, dvs_r};
      if (!trial[32]) begin
         rem_nx = trial[31:0];
         quo_nx = {quo_r[30:0], 1'b1};
      end else begin
         rem_nx = shifted[31:0];
         quo_nx = {quo_r[30:0], 1'b0};
      end
      // sign fix is folded into the last iteration so the result is
      // registered as FIX (the done cycle) begins
      quo_fix = div0 ? '1 : (neg_q ? (32'd0 - quo_nx) : quo_nx);
      rem_fix = neg_r ? (32'd0 - rem_nx) : rem_nx;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
         prod_r  <= '0;
         mul_cnt <= '0;
`ifdef MULDIV_DIV_EN
         rem_r   <= '0;
         quo_r   <= '0;
         dvs_r   <= '0;
         div_cnt <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
`endif
      end else if (bus.flush) begin
         state   <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         mul_cnt <= '0;
`ifdef MULDIV_DIV_EN
         div_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               if (accept) begin
                  busy_r <= 1'b1;
                  if (!is_div) begin
                     if (MUL_LAT == 1) begin
                        {hi_r, lo_r} <= product;
                        done_r       <= 1'b1;
                     end else begin
                        prod_r  <= product;
                        mul_cnt <= 3'd1;
                        state   <= MUL;
                     end
                  end else begin
`ifdef MULDIV_DIV_EN
                     rem_r   <= '0;
                     quo_r   <= abs_a;
                     dvs_r   <= abs_b;
                     div_cnt <= '0;
                     neg_q   <= signed_op & (bus.srca[31] ^ bus.srcb[31]);
                     neg_r   <= signed_op & bus.srca[31];
                     div0    <= (bus.srcb == 32'd0);
                     state   <= DIV;
`else
                     hi_r    <= '0;
                     lo_r    <= '0;
                     done_r  <= 1'b1;
`endif
                  end
               end
            end
            MUL: begin
               if (mul_cnt == MUL_LAST) begin
                  {hi_r, lo_r} <= prod_r;
                  done_r       <= 1'b1;
                  mul_cnt      <= '0;
                  state        <= IDLE;
               end else begin
                  mul_cnt <= mul_cnt + 3'd1;
               end
            end
            DIV: begin
`ifdef MULDIV_DIV_EN
               rem_r <= rem_nx;
               quo_r <= quo_nx;
               if (div_cnt == 5'd31) begin
                  hi_r    <= rem_fix;
                  lo_r    <= quo_fix;
                  done_r  <= 1'b1;
                  div_cnt <= '0;
                  state   <= FIX;
               end else begin
                  div_cnt <= div_cnt + 5'd1;
               end
`else
               state <= IDLE;
`endif
            end
            FIX: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_engine.sv
// tb_muldiv_engine -- scoreboard bench for muldiv_engine (MUL_LAT=3).
// Expected results follow the MULDIV_DIV_EN setting of the build.
module tb_muldiv_engine;

   localparam int unsigned LAT = 3;
`ifdef MULDIV_DIV_EN
   localparam int DIV_LAT = 33;
`else
   localparam int DIV_LAT = 1;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   muldiv_engine_if bus ();

   muldiv_engine #(.MUL_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   exp_t        q[$];
   exp_t        e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] dv(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
      return v;
`else
      return '0;
`endif
   endfunction

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat);
      q.push_back('{hi, lo, cyc + lat});
      last_hi = hi;
      last_lo = lo;
   endtask

   // called right after a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat,
                        input bit expect_done);
      bus.start = 1'b1;
      bus.op    = op;
      bus.srca  = a;
      bus.srcb  = b;
      if (expect_done) push(hi, lo, lat);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.srca  = $urandom;
      bus.srcb  = $urandom;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!bus.busy && q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("idle_wait", 32'(ok), 32'd1);
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bus.done) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: done=1 hi=0x%08h lo=0x%08h at cycle %0d, required no completion",
                     bus.hi, bus.lo, cyc);
         end else begin
            e = q.pop_front();
            check("result_hi", bus.hi, e.hi);
            check("result_lo", bus.lo, e.lo);
            check("done_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hold;
      logic [1:0] hold_op;

      bus.start = 1'b0;
      bus.op    = '0;
      bus.srca  = '0;
      bus.srcb  = '0;
      bus.flush = 1'b0;
      reset     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);

      // accepted in the first cycle out of reset
      reset = 1'b1;
      issue(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 1'b1);
      wait_idle();
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, 1'b1);
      wait_idle();
      issue(2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, LAT, 1'b1);
      wait_idle();
      issue(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, LAT, 1'b1);
      wait_idle();

      // DIV -7 / 2 with busy-length measurement
      issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFF), dv(32'hFFFF_FFFD), DIV_LAT, 1'b1);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'(DIV_LAT));
      wait_idle();

      issue(2'd3, 32'h1234_5678, 32'h0000_0000, dv(32'h1234_5678), dv(32'hFFFF_FFFF), DIV_LAT, 1'b1);
      wait_idle();
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0000_0000), dv(32'h8000_0000), DIV_LAT, 1'b1);
      wait_idle();
      issue(2'd3, 32'd100, 32'd7, dv(32'd2), dv(32'd14), DIV_LAT, 1'b1);
      wait_idle();
      issue(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, dv(32'h0000_0001), dv(32'hFFFF_FFFD), DIV_LAT, 1'b1);
      wait_idle();
      issue(2'd2, 32'hFFFF_FFF8, 32'h0000_0000, dv(32'hFFFF_FFF8), dv(32'hFFFF_FFFF), DIV_LAT, 1'b1);
      wait_idle();

      // start held through the done cycle: exactly one completion
      bus.start = 1'b1;
      bus.op    = 2'd1;
      bus.srca  = 32'h0001_0000;
      bus.srcb  = 32'h0003_0000;
      push(32'h0000_0003, 32'h0000_0000, LAT);
      repeat (LAT + 1) @(negedge clk);
      bus.start = 1'b0;
      wait_idle();

      // flush and start together: not accepted
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = 2'd0;
      bus.srca  = 32'd5;
      bus.srcb  = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("flush_start_busy", 32'(bus.busy), 32'd0);
      repeat (LAT + 2) @(negedge clk);
      check("flush_start_hi", bus.hi, last_hi);
      check("flush_start_lo", bus.lo, last_lo);

      // flush on the completion edge: no done, results held
      issue(2'd0, 32'd9, 32'd9, 32'd0, 32'd81, LAT, 1'b0);
      repeat (LAT - 2) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_done_done", 32'(bus.done), 32'd0);
      check("flush_done_busy", 32'(bus.busy), 32'd0);
      check("flush_done_hi", bus.hi, last_hi);
      check("flush_done_lo", bus.lo, last_lo);

      // DIVU flushed at +10, then MULTU 3x5
`ifdef MULDIV_DIV_EN
      issue(2'd3, 32'd100, 32'd7, 32'd0, 32'd0, DIV_LAT, 1'b0);
`else
      issue(2'd3, 32'd100, 32'd7, 32'd0, 32'd0, DIV_LAT, 1'b1);
`endif
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_div_busy", 32'(bus.busy), 32'd0);
      check("flush_div_hi", bus.hi, last_hi);
      check("flush_div_lo", bus.lo, last_lo);
      repeat (40) @(negedge clk);
      issue(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, LAT, 1'b1);
      wait_idle();

      // start held while busy, then reset in flight
`ifdef MULDIV_DIV_EN
      hold    = 5;
      hold_op = 2'd2;
`else
      hold    = 2;
      hold_op = 2'd0;
`endif
      bus.start = 1'b1;
      bus.op    = hold_op;
      bus.srca  = 32'h0000_0040;
      bus.srcb  = 32'h0000_0003;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("held_busy", 32'(bus.busy), 32'd1);
      end
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      last_hi = '0;
      last_lo = '0;
      repeat (40) @(negedge clk);
      check("abort_idle_busy", 32'(bus.busy), 32'd0);

      repeat (5) @(negedge clk);
      check("pending_expectations", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/muldiv_engine.md
MULDIV_ENGINE -- requirements
Module: muldiv_engine

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, multiply latency in cycles (legal 1..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request valid; accepted only when busy=0 and flush=0.
REQ-005 SHALL have port op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 SHALL have port srca  input  32  multiplicand/dividend.
REQ-007 SHALL have port srcb  input  32  multiplier/divisor.
REQ-008 SHALL have port flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port busy  output  1  operation in flight.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port hi  output  32  high product / remainder.
REQ-012 SHALL have port lo  output  32  low product / quotient.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX; IDLE->MUL on accepted op 0/1; IDLE->DIV on accepted op 2/3; DIV->FIX after 32 iterations; MUL/FIX->IDLE on completion.
REQ-014 SHALL latch op, srca, srcb in the accept cycle; later input changes do not affect the result.
REQ-015 SHALL assert done exactly MUL_LAT cycles after the accept cycle for MULT/MULTU.
REQ-016 SHALL assert done exactly 33 cycles after the accept cycle for DIV/DIVU (32 restoring iterations + 1 sign-fix cycle).
REQ-017 SHALL drive busy=1 from the cycle after accept through the done cycle inclusive; busy=0 otherwise.
REQ-018 SHALL ignore start while busy=1, including in the done cycle; no queuing.
REQ-019 SHALL update hi/lo only in the done cycle and hold them otherwise.
REQ-020 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; {hi,lo}=product.
REQ-021 SHALL compute DIV on magnitudes: quotient sign = sign(srca) xor sign(srcb); remainder sign = sign(srca); lo=quotient, hi=remainder.
REQ-022 SHALL give 0x80000000 DIV 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-023 SHALL, on divide by zero (either signedness), keep normal latency and give lo=0xFFFFFFFF, hi=srca.
REQ-024 SHALL, on flush=1, return to IDLE next cycle, drop the operation without done, and leave hi/lo unchanged.
REQ-025 SHALL let flush win over start in the same cycle; the request is not accepted.
REQ-026 SHALL let flush win over completion in the same cycle: done=0 and hi/lo unchanged.

Reset
REQ-027 SHALL, with reset=0 at a clock edge, enter IDLE and set busy=0, done=0, hi=0, lo=0, and clear all iteration counters.
REQ-028 SHALL abort an in-flight operation on reset with no done pulse.
REQ-029 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL have macro MULDIV_DIV_EN; when defined, DIV/DIVU follow REQ-016..REQ-023.
REQ-031 SHALL, with MULDIV_DIV_EN undefined, omit divider hardware; DIV/DIVU then complete in 1 cycle (done the cycle after accept) with hi=0, lo=0; MULT/MULTU are unchanged.

Verification
REQ-032 SHALL test MULT 0xFFFFFFFF x 0x00000002, MUL_LAT=3 -> done 3 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL test DIV 0xFFFFFFF9 (-7) / 2 -> done at +33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high for 33 cycles.
REQ-035 SHALL test DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678, done at +33.
REQ-036 SHALL test DIVU started, flush at +10, then new MULTU 3x5 -> no done for the DIVU, hi/lo hold the prior result, then lo=15, hi=0.
REQ-037 SHALL test start held high during busy plus reset=0 at +5 of a DIV -> no second accept, no done, all outputs 0.
